slow_mem_responder: RTL and testbench

//  Memory-side responder for the 128-bit cache-line interface driven by D_cache/I_cache
//  (mem_read/mem_write/mem_addr[31:4]/mem_wdata -> mem_rdata/mem_ready).

---
 rtl/slow_mem_responder.sv | 98 +++++++++
 tb/tb_slow_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_mem_responder.sv
// Fixed-latency line memory behind the I/D caches.
// One request in flight; write wins on read+write.
module slow_mem_responder #(
  parameter int LATENCY    = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_wdata,
  output logic [127:0]      mem_rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err_rw_conflict
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [127:0]          r_wdata;
  logic                  r_wr;
  logic                  r_rd;
  logic [127:0]          r_mem [0:(1<<DEPTH_LOG2)-1];

  logic w_fire;
  logic w_req;
  logic w_unused_addr;

  assign w_fire = (r_state == S_BUSY) && (r_cnt == 8'd0);
  assign w_req  = mem_read | mem_write;
  assign busy   = (r_state == S_BUSY) || (r_state == S_RESP);

  // upper line-address bits alias onto the array
  assign w_unused_addr = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (w_fire && r_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= 8'd0;
      r_idx           <= '0;
      r_wdata         <= '0;
      r_wr            <= 1'b0;
      r_rd            <= 1'b0;
      mem_rdata       <= '0;
      mem_ready       <= 1'b0;
      err_rw_conflict <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx   <= mem_addr[DEPTH_LOG2-1:0];
            r_wdata <= mem_wdata;
            r_wr    <= mem_write;
            r_rd    <= mem_read;
            r_cnt   <= 8'(LATENCY - 1);
            r_state <= S_BUSY;
            if (mem_read && mem_write) begin
              err_rw_conflict <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 8'd0) begin
            mem_ready <= 1'b1;
            r_state   <= S_RESP;
            if (r_rd) begin
              mem_rdata <= r_wr ? r_wdata : r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RESP: begin
          mem_ready <= 1'b0;
          r_state   <= S_COOL;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_mem_responder.sv
// Randomized scoreboard bench for slow_mem_responder.
// Two instances (latency 8 and 1) share one driver.
module tb_slow_mem_responder;

  typedef struct {
    int           cyc;
    logic [127:0] data;
    bit           err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rd, wr;
  logic [27:0]  addr;
  logic [127:0] wdata;
  bit           sel;

  logic [127:0] rdata0, rdata1;
  logic         ready0, ready1, busy0, busy1, err0, err1;

  logic [127:0] w_rdata;
  logic         w_ready, w_busy, w_err;

  assign w_rdata = sel ? rdata1 : rdata0;
  assign w_ready = sel ? ready1 : ready0;
  assign w_busy  = sel ? busy1  : busy0;
  assign w_err   = sel ? err1   : err0;

  slow_mem_responder #(.LATENCY(8), .DEPTH_LOG2(10), .ADDR_W(28)) u_l8 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(rd & ~sel), .mem_write(wr & ~sel),
    .mem_addr(addr), .mem_wdata(wdata),
    .mem_rdata(rdata0), .mem_ready(ready0),
    .busy(busy0), .err_rw_conflict(err0)
  );

  slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(10), .ADDR_W(28)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(rd & sel), .mem_write(wr & sel),
    .mem_addr(addr), .mem_wdata(wdata),
    .mem_rdata(rdata1), .mem_ready(ready1),
    .busy(busy1), .err_rw_conflict(err1)
  );

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           last_acc [2];
  logic [127:0] last_rd  [2];
  bit           exp_err  [2];
  logic [127:0] model [bit [10:0]];
  exp_t         q [$];
  logic [9:0]   pool [12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat();
    return sel ? 1 : 8;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Monitor: every ready pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sel ? ready0 : ready1) begin
        total++;
        bad++;
        $display("FAIL idle_dut_ready: got pulse at cycle %0d want none", cyc);
      end
      if (w_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready: got pulse at cycle %0d want none", cyc);
        end else begin
          e = q.pop_front();
          chk("ready_cycle", 128'(cyc), 128'(e.cyc));
          chk("rdata", w_rdata, e.data);
          chk("err_flag", 128'(w_err), 128'(e.err));
          chk("busy_at_ready", 128'(w_busy), 128'd1);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timeout("drain");
      q.delete();
    end
    @(negedge clk);
    chk("busy_after", 128'(w_busy), 128'd0);
  endtask

  // Accepted at the first sampled edge once the previous
  // request is L+3 edges old (busy, ready, cool-down).
  task automatic issue(input bit r, input bit w, input logic [27:0] a,
                       input logic [127:0] d, input bit pert);
    int k, acc, n;
    bit [10:0] key;
    exp_t e;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    k = cyc + 1;
    acc = (k >= last_acc[sel] + lat() + 3) ? k : last_acc[sel] + lat() + 3;
    last_acc[sel] = acc;
    key = {sel, a[9:0]};
    if (w) model[key] = d;
    if (r) last_rd[sel] = model[key];
    if (r && w) exp_err[sel] = 1'b1;
    e.cyc = acc + lat();
    e.data = last_rd[sel];
    e.err = exp_err[sel];
    q.push_back(e);
    n = 0;
    if (pert) begin
      while (cyc < acc && n < 200) begin
        @(negedge clk);
        n++;
      end
    end else begin
      do begin
        @(negedge clk);
        n++;
      end while (!w_ready && n < 200);
    end
    if (n >= 200) timeout("accept_or_ready");
    rd = 1'b0;
    wr = 1'b0;
    if (pert) begin
      addr = 28'($urandom());
      wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    drain();
  endtask

  task automatic held(input logic [27:0] a);
    int k, t;
    exp_t e;
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = a;
    k = cyc + 1;
    t = (k >= last_acc[sel] + lat() + 3) ? k : last_acc[sel] + lat() + 3;
    while (t <= k + 19) begin
      last_acc[sel] = t;
      last_rd[sel] = model[{sel, a[9:0]}];
      e.cyc = t + lat();
      e.data = last_rd[sel];
      e.err = exp_err[sel];
      q.push_back(e);
      t += lat() + 3;
    end
    repeat (20) @(negedge clk);
    rd = 1'b0;
    drain();
  endtask

  function automatic logic [27:0] pick();
    return {18'($urandom()), pool[$urandom_range(0, 11)]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [27:0]  a;
    logic [127:0] d;
    int op;
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
    for (int s = 0; s < 2; s++) begin
      last_acc[s] = -100;
      last_rd[s] = '0;
      exp_err[s] = 1'b0;
    end
    for (int i = 0; i < 12; i++) pool[i] = 10'($urandom());
    pool[0] = 10'h010;
    pool[1] = 10'h000;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(ready0), 128'd0);
    chk("rst_busy", 128'(busy0), 128'd0);
    chk("rst_rdata", rdata0, 128'd0);
    chk("rst_err", 128'(err0), 128'd0);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 12; i++)
        issue(1'b0, 1'b1, {18'($urandom()), pool[i]}, rnd128(),
              1'($urandom_range(0, 1)));
    end

    sel = 1'b0;
    issue(1'b0, 1'b1, 28'h0000010,
          128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    issue(1'b1, 1'b0, 28'h0000010, '0, 1'b0);
    chk("dir_readback", rdata0, 128'h0123456789ABCDEF0123456789ABCDEF);

    issue(1'b0, 1'b1, 28'h0000400, {32{4'hA}}, 1'b0);
    issue(1'b1, 1'b0, 28'h0000000, '0, 1'b0);
    chk("dir_alias", rdata0, {32{4'hA}});

    // Reset mid-request: write must not land, no pulse afterwards
    a = {18'd5, pool[3]};
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = rnd128();
    repeat (3) @(negedge clk);
    wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 128'(ready0), 128'd0);
    chk("abort_busy", 128'(busy0), 128'd0);
    chk("abort_rdata", rdata0, 128'd0);
    chk("abort_err", 128'(err0), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    for (int s = 0; s < 2; s++) begin
      last_acc[s] = -100;
      last_rd[s] = '0;
      exp_err[s] = 1'b0;
    end
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", 128'(busy0), 128'd0);
    issue(1'b1, 1'b0, a, '0, 1'b0);

    issue(1'b1, 1'b1, {18'd9, pool[4]}, {32{4'h5}}, 1'b0);
    chk("conflict_rdata", rdata0, {32{4'h5}});
    chk("conflict_err", 128'(err0), 128'd1);
    issue(1'b1, 1'b0, {18'd1, pool[4]}, '0, 1'b1);
    chk("conflict_sticky", 128'(err0), 128'd1);

    held({18'd0, pool[5]});

    sel = 1'b1;
    held({18'd2, pool[6]});
    d = rnd128();
    issue(1'b0, 1'b1, {18'd3, pool[7]}, d, 1'b1);
    issue(1'b1, 1'b0, {18'd4, pool[7]}, '0, 1'b1);
    chk("l1_readback", rdata1, d);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 40; i++) begin
        op = $urandom_range(0, 9);
        issue(op < 5 || op == 9, op >= 5, pick(), rnd128(),
              1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
